// File: rtl/addsub_pkg.sv
// Shared state encoding, default sizing and counter-width helper for addsub_seq.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CHUNK_DEF = 8;

    // A single-chunk build still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic w_c;

    always_comb begin
        w_c  = cin;
        s    = '0;
        cmsb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = w_c;
            s[i] = x[i] ^ y[i] ^ w_c;
            w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
        end
    end

    assign cout = w_c;

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK per cycle, carry-in = sub, start/done handshake.
// Flag logic (ovf/zero/neg) is built only when ADDSUB_FLAGS_EN is defined.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_x,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [31:0]      w_sh;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_nxt;

    // Select chunk cnt from the captured operands and splice the result back into sum.
    always_comb begin
        w_sh      = 32'(r_cnt) * CHUNK;
        w_a_sh    = r_a >> w_sh;
        w_b_sh    = r_b >> w_sh;
        w_x       = w_a_sh[CHUNK-1:0];
        w_y       = w_b_sh[CHUNK-1:0];
        w_sum_nxt = (r_sum & ~(CMASK << w_sh)) | (WIDTH'(w_s) << w_sh);
        w_last    = (r_cnt == CW'(NCHUNK - 1));
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co),
        .cmsb (w_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b_x;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) r_cout <= w_co;
                end
                default: ;
            endcase
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic r_ovf;
    logic r_zero;
    logic r_neg;

    // Flags only make sense once the top chunk has been added.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf  <= w_cmsb ^ w_co;
            r_zero <= (w_sum_nxt == '0);
            r_neg  <= w_sum_nxt[WIDTH-1];
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (default 32-bit / 8-bit chunk build).
module tb_addsub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b_x;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    int n_cmp;
    int n_bad;

    addsub_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b_x   (b_x),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // Drives one request; returns edges from accept to first done sample (-1 on timeout).
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         output int lat, output logic accepted_busy);
        a     = ta;
        b_x   = tb;
        sub   = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b_x   = 32'h1234_5678;
        sub   = ~ts;
        accepted_busy = busy;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; sub = 1'b0; a = '0; b_x = '0;
        #12;
        n_cmp++;
        if ({busy, done, cout, ovf, zero, neg} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, done, cout, ovf, zero, neg});
        end
        n_cmp++;
        if (sum !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_sum: got %h want 00000000", sum);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                            input logic ts, input logic [31:0] e_sum, input logic e_cout,
                            input logic e_ovf, input logic e_zero, input logic e_neg);
        int   lat;
        logic bz;
        do_op(ta, tb, ts, lat, bz);
        n_cmp++;
        if (bz !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy: got %b want 1", name, bz);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want 4", name, lat);
        end
        n_cmp++;
        if (sum !== e_sum) begin
            n_bad++;
            $display("FAIL %s_sum: got %h want %h", name, sum, e_sum);
        end
        n_cmp++;
        if (cout !== e_cout) begin
            n_bad++;
            $display("FAIL %s_cout: got %b want %b", name, cout, e_cout);
        end
        n_cmp++;
        if ({ovf, zero, neg} !== ({e_ovf, e_zero, e_neg} & {3{FLAGS}})) begin
            n_bad++;
            $display("FAIL %s_flags: got ovf/zero/neg %b want %b", name, {ovf, zero, neg},
                     {e_ovf, e_zero, e_neg} & {3{FLAGS}});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00 || sum !== e_sum) begin
            n_bad++;
            $display("FAIL %s_after: got busy/done %b sum %h want 00 sum %h", name,
                     {busy, done}, sum, e_sum);
        end
    endtask

    task automatic test_add();
        check_op("add", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        check_op("sub", 32'd5, 32'hFFFF_FFFC, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        check_op("ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_zero_carry();
        check_op("zero", 32'd3, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_op("chunk_carry", 32'h0000_00FF, 32'd1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        check_op("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int          n_done;
        int          done_at [2];
        logic [31:0] done_sum [2];
        n_done = 0;
        done_at[0] = -1; done_at[1] = -1;
        done_sum[0] = '0; done_sum[1] = '0;
        a = 32'd100; b_x = 32'd1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 1; j <= 16; j++) begin
            if (done) begin
                if (n_done < 2) begin
                    done_at[n_done]  = j - 1;
                    done_sum[n_done] = sum;
                end
                n_done++;
            end
            a     = 32'(100 * (j + 1));
            start = (j < 10);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        n_cmp++;
        if (n_done !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d done pulses want 2", n_done);
        end
        n_cmp++;
        if (done_at[0] !== 4 || done_sum[0] !== 32'd101) begin
            n_bad++;
            $display("FAIL b2b_first: got edge %0d sum %0d want edge 4 sum 101", done_at[0], done_sum[0]);
        end
        n_cmp++;
        if (done_at[1] !== 10 || done_sum[1] !== 32'd701) begin
            n_bad++;
            $display("FAIL b2b_second: got edge %0d sum %0d want edge 10 sum 701", done_at[1], done_sum[1]);
        end
    endtask

    task automatic test_reset_mid();
        int   n_done;
        int   lat;
        logic bz;
        a = 32'h1111_1111; b_x = 32'h2222_2222; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cout, ovf, zero, neg} !== 6'b0 || sum !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got ctrl %b sum %h want 000000 sum 00000000",
                     {busy, done, cout, ovf, zero, neg}, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d active cycles want 0", n_done);
        end
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, bz);
        n_cmp++;
        if (lat !== 4 || sum !== 32'h2345_6789 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_recover: got lat %0d sum %h cout %b want 4 23456789 0", lat, sum, cout);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_zero_carry();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
